seq_shift_add_mult: RTL and testbench

Parametrised sequential shift-add multiplier, the successor to the team's fixed 4x4 combinational array multiplier. Computes a full-width `2*WIDTH` product of two `WIDTH`-bit operands over `WIDTH` clock cycles using a single `WIDTH`-bit adder, trading latency for area. It uses valid/ready handshakes on both sides so it can sit directly in datapath pipelines. An optional compile-time signed mode is available.

---
 rtl/seq_shift_add_mult.sv | 128 ++++++++++++
 tb/tb_seq_shift_add_mult.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_shift_add_mult.sv
// rtl/seq_shift_add_mult.sv - sequential shift-add multiplier, WIDTH cycles per product, valid/ready on both sides
// Optional two's complement operand mode is compiled in with MULT_SIGNED_EN.
module seq_shift_add_mult #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     m,
    input  logic [WIDTH-1:0]     q,
    input  logic                 sgn,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p,
    output logic                 busy
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_m;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_a;
    logic [CW-1:0]      r_cnt;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_a_next;
    logic [WIDTH-1:0]   w_q_next;
    logic [2*WIDTH-1:0] w_prod;
    logic               w_last;
    logic [WIDTH-1:0]   w_m_load;
    logic [WIDTH-1:0]   w_q_load;
    logic [2*WIDTH-1:0] w_p_load;

    // The carry is folded into the sum: after the shift it is always zero again.
    assign w_sum    = r_q[0] ? ({1'b0, r_a} + {1'b0, r_m}) : {1'b0, r_a};
    assign w_a_next = w_sum[WIDTH:1];
    assign w_q_next = {w_sum[0], r_q[WIDTH-1:1]};
    assign w_prod   = {w_a_next, w_q_next};
    assign w_last   = (r_cnt == CW'(WIDTH - 1));

`ifdef MULT_SIGNED_EN
    logic r_neg;
    logic w_neg_load;

    // Magnitudes are unsigned WIDTH bits, so the most-negative operand becomes 2^(WIDTH-1).
    assign w_m_load   = (sgn && m[WIDTH-1]) ? -m : m;
    assign w_q_load   = (sgn && q[WIDTH-1]) ? -q : q;
    assign w_neg_load = sgn & (m[WIDTH-1] ^ q[WIDTH-1]);
    assign w_p_load   = r_neg ? -w_prod : w_prod;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_neg <= 1'b0;
        end else if (r_state == S_IDLE && in_valid) begin
            r_neg <= w_neg_load;
        end
    end
`else
    logic w_unused_sgn;

    assign w_unused_sgn = sgn;
    assign w_m_load     = m;
    assign w_q_load     = q;
    assign w_p_load     = w_prod;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_m       <= '0;
            r_q       <= '0;
            r_a       <= '0;
            r_cnt     <= '0;
            p         <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_m      <= w_m_load;
                        r_q      <= w_q_load;
                        r_a      <= '0;
                        r_cnt    <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        r_state  <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_a <= w_a_next;
                    r_q <= w_q_next;
                    if (w_last) begin
                        p         <= w_p_load;
                        out_valid <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// tb/tb_seq_shift_add_mult.sv - scoreboard bench for seq_shift_add_mult (WIDTH=8 directed, plus 2/4/16 sweeps)
// Signed vectors are exercised when MULT_SIGNED_EN is defined.
module tb_seq_shift_add_mult;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           sw_rst = 1'b1;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   m;
    logic [W-1:0]   q;
    logic           sgn;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] p;
    logic           busy;

    int n_vec = 0;
    int n_err = 0;

    logic [2*W-1:0] sb_q[$];

    always #5 clk = ~clk;

    seq_shift_add_mult #(.WIDTH(W)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .m         (m),
        .q         (q),
        .sgn       (sgn),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the accept edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input bit push, input logic [2*W-1:0] exp);
        int w;
        w = 0;
        while (!in_ready && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        if (!in_ready) begin
            chk("issue_timeout", 64'd0, 64'd1);
            return;
        end
        in_valid = 1'b1;
        m        = a;
        q        = b;
        sgn      = s;
        if (push) sb_q.push_back(exp);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while (!in_ready && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        chk("wait_idle", in_ready, 1);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL product: unexpected output 0x%0h, expected none", p);
            end else begin
                chk("product", p, sb_q.pop_front());
            end
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_sw
        localparam int SW   = (g == 0) ? 2 : ((g == 1) ? 4 : 16);
        localparam int NOPS = (SW == 4) ? 1256 : 1000;

        logic            iv;
        logic            ir;
        logic            ov;
        logic            orr;
        logic            sg;
        logic            bz;
        logic [SW-1:0]   a;
        logic [SW-1:0]   b;
        logic [2*SW-1:0] pp;
        logic [2*SW-1:0] q_exp[$];
        bit              done = 1'b0;

        seq_shift_add_mult #(.WIDTH(SW)) u_dut (
            .clk       (clk),
            .rst       (sw_rst),
            .in_valid  (iv),
            .in_ready  (ir),
            .m         (a),
            .q         (b),
            .sgn       (sg),
            .out_valid (ov),
            .out_ready (orr),
            .p         (pp),
            .busy      (bz)
        );

        function automatic logic [2*SW-1:0] ref_prod(input logic [SW-1:0] x, input logic [SW-1:0] y,
                                                     input logic s);
            logic [2*SW-1:0] xe;
            logic [2*SW-1:0] ye;
            xe = {{SW{1'b0}}, x};
            ye = {{SW{1'b0}}, y};
            if (s) begin
                xe = {{SW{x[SW-1]}}, x};
                ye = {{SW{y[SW-1]}}, y};
            end
            return xe * ye;
        endfunction

        initial begin
            iv  = 1'b0;
            orr = 1'b1;
            sg  = 1'b0;
            a   = '0;
            b   = '0;
            wait (sw_rst == 1'b0);
            @(posedge clk); #1;
            for (int k = 0; k < NOPS; k++) begin
                logic [SW-1:0] x;
                logic [SW-1:0] y;
                logic          s;
                int            w;
                if (SW == 4 && k < 256) begin
                    x = SW'(k);
                    y = SW'(k >> 4);
                end else begin
                    x = SW'($urandom);
                    y = SW'($urandom);
                end
                s = 1'b0;
`ifdef MULT_SIGNED_EN
                s = 1'($urandom_range(0, 1));
`endif
                w = 0;
                while (!ir && w < 100) begin
                    @(posedge clk); #1;
                    w++;
                end
                if (!ir) begin
                    chk($sformatf("sweep_w%0d_timeout", SW), 64'd0, 64'd1);
                    break;
                end
                iv = 1'b1;
                a  = x;
                b  = y;
                sg = s;
                q_exp.push_back(ref_prod(x, y, s));
                @(posedge clk); #1;
                iv = 1'b0;
            end
            for (int w = 0; w < 100 && q_exp.size() != 0; w++) @(posedge clk);
            chk($sformatf("sweep_w%0d_drain", SW), q_exp.size(), 0);
            done = 1'b1;
        end

        always @(negedge clk) begin
            if (!sw_rst && ov && orr) begin
                if (q_exp.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL sweep_w%0d: unexpected output 0x%0h, expected none", SW, pp);
                end else begin
                    chk($sformatf("sweep_w%0d", SW), pp, q_exp.pop_front());
                end
            end
        end
    end

    initial begin
        #22 sw_rst = 1'b0;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int     lat;
        int     k;
        bit     acc;
        time    t_acc[4];
        logic [W-1:0]   bm[4];
        logic [W-1:0]   bq[4];
        logic [2*W-1:0] be[4];

        rst       = 1'b1;
        in_valid  = 1'b0;
        m         = '0;
        q         = '0;
        sgn       = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_p", p, 0);
        rst = 1'b0;

        issue(8'd13, 8'd11, 1'b0, 1'b1, 16'h008F);
        chk("busy_calc", busy, 1);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, W);
        wait_idle();

        // Abort an operation mid-CALC; the previous product must clear at once.
        issue(8'd255, 8'd255, 1'b0, 1'b0, 16'h0000);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_in_ready", in_ready, 1);
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_p", p, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        issue(8'd255, 8'd255, 1'b0, 1'b1, 16'hFE01);
        issue(8'd0,   8'd200, 1'b0, 1'b1, 16'h0000);
        issue(8'd1,   8'd255, 1'b0, 1'b1, 16'h00FF);
        wait_idle();

        out_ready = 1'b0;
        issue(8'd100, 8'd3, 1'b0, 1'b1, 16'h012C);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("bp_out_valid_rise", out_valid, 1);
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            m        = 8'd7;
            q        = 8'd7;
            @(posedge clk); #1;
            chk("bp_p_stable", p, 16'h012C);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_in_ready", in_ready, 1);
        chk("bp_release_out_valid", out_valid, 0);
        chk("bp_release_p_held", p, 16'h012C);
        issue(8'd9, 8'd9, 1'b0, 1'b1, 16'h0051);
        wait_idle();

        bm = '{8'd2, 8'd17, 8'd200, 8'd128};
        bq = '{8'd3, 8'd15, 8'd100, 8'd2};
        be = '{16'h0006, 16'h00FF, 16'h4E20, 16'h0100};
        k        = 0;
        in_valid = 1'b1;
        m        = bm[0];
        q        = bq[0];
        sb_q.push_back(be[0]);
        for (int c = 0; c < 200 && k < 4; c++) begin
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) begin
                t_acc[k] = $time;
                k++;
                if (k < 4) begin
                    m = bm[k];
                    q = bq[k];
                    sb_q.push_back(be[k]);
                end
            end
        end
        in_valid = 1'b0;
        chk("b2b_accepts", k, 4);
        for (int i = 1; i < 4; i++) chk("b2b_interval", (t_acc[i] - t_acc[i-1]) / 10, W + 2);
        wait_idle();

`ifdef MULT_SIGNED_EN
        issue(8'hFF, 8'hFF, 1'b1, 1'b1, 16'h0001);
        issue(8'h80, 8'h80, 1'b1, 1'b1, 16'h4000);
        issue(8'h80, 8'h7F, 1'b1, 1'b1, 16'hC080);
        issue(8'h05, 8'hFD, 1'b1, 1'b1, 16'hFFF1);
        issue(8'hFF, 8'hFF, 1'b0, 1'b1, 16'hFE01);
`else
        issue(8'hFF, 8'hFF, 1'b1, 1'b1, 16'hFE01);
        issue(8'h05, 8'hFD, 1'b1, 1'b1, 16'h04F1);
`endif
        wait_idle();
        for (int w = 0; w < 50 && sb_q.size() != 0; w++) @(posedge clk);
        chk("sb_drain", sb_q.size(), 0);

        for (int w = 0; w < 40000 && !(g_sw[0].done && g_sw[1].done && g_sw[2].done); w++)
            @(posedge clk);
        chk("sweeps_done", {g_sw[0].done, g_sw[1].done, g_sw[2].done}, 3'b111);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
